option_feeder: RTL and testbench
================================

# option_feeder

Sequencer that streams candidate line options into the solver and recycles survivors between rounds. It holds every candidate option of a puzzle in a circular buffer. Each round it emits, per line, a line-index beat followed by that line's remaining options, and re-enqueues the options the solver flags with put_back_to_FIFO. It drives old_options_amnt, started and the per-line option stream, and repeats rounds until the solver reports solved or a round removes nothing.

## Interface
- MAX_ROWS, 3, maximum puzzle rows
- MAX_COLS, 3, maximum puzzle columns
- W, max(MAX_ROWS,MAX_COLS), option word width
- DEPTH, 64, buffer entries; power of two
- CW, 7, per-line option count width
- L = MAX_ROWS+MAX_COLS lines; LW = clog2(L)
- One clock; reset is synchronous and active-low.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- num_rows  in  clog2(MAX_ROWS+1)  rows in this puzzle, sampled at load_last
- num_cols  in  clog2(MAX_COLS+1)  columns in this puzzle, sampled at load_last
- load_valid  in  1  load beat present
- load_line  in  LW  line of load beat; rows are 0..num_rows-1, then columns
- load_option  in  W  option bits
- load_last  in  1  final load beat; qualified by load_valid
- load_ready  out  1  high in IDLE
- put_back_to_FIFO  in  1  solver verdict for the option beat of the previous cycle
- solved  in  1  solver board-complete flag
- started  out  1  one-cycle pulse before round 1
- option  out  W  stream beat: line index, zero-extended, or option
- option_valid  out  1  beat on option is valid
- old_options_amnt  out  L×CW  per-line counts for the current round
- busy  out  1  not IDLE/DONE
- done  out  1  sticky; solver reported solved
- stuck  out  1  sticky; a round removed nothing and the board is not solved
- overflow  out  1  sticky; a load beat was dropped because the buffer was full

## Operation
- States: IDLE, START, INDEX, OPTS, FLUSH, CHECK, DONE.
- IDLE
  - Each accepted load beat writes {line, option} at the tail and increments count[line].
  - A beat arriving with the buffer full is dropped and sets overflow.
  - Load beats must arrive grouped and in ascending line order.
  - load_last moves to START.
- START: started=1 for one cycle; line=0; go to INDEX.
- INDEX
  - Emit option=line with option_valid=1.
  - If remaining=old_options_amnt[line] is nonzero, go to OPTS; otherwise advance line.
  - After line num_rows+num_cols-1, go to FLUSH.
- OPTS
  - Pop the head, emit its option, and hold the popped entry in pend.
  - Decrement remaining; at zero, advance line to INDEX, or to FLUSH after the last line.
- Verdict handling, every cycle following an option beat:
  - put_back_to_FIFO=1: push pend to the tail and increment new_count[pend.line].
  - put_back_to_FIFO=0: discard pend and set removed_any.
  - Push at the tail and pop at the head may occur in the same cycle.
- FLUSH: absorbs the verdict of the final option beat; option_valid=0.
- CHECK
  - old_options_amnt ← new_count; new_count ← 0.
  - solved=1 → DONE with done=1.
  - Else removed_any=0 → DONE with stuck=1.
  - Else clear removed_any and go to INDEX with line=0 (no started pulse).
- Lines with zero remaining options still receive an index beat.
- Counts are never incremented past the initial load total; buffer occupancy never grows after load.
- DONE: holds outputs until reset. Load is not accepted.

## Timing
- Reset values:
  - option=0, option_valid=0, started=0, busy=0, done=0, stuck=0, overflow=0, load_ready=1.
  - All old_options_amnt=0; buffer empty; state IDLE.
- started is asserted the cycle after the load_last beat; the first index beat follows the cycle after that.
- Beats are back-to-back, one per cycle, with no backpressure.
- Round length is L_active + total options beats, plus FLUSH and CHECK (2 cycles).
- put_back_to_FIFO and solved are ignored in every cycle not following an option beat. solved is used only in CHECK.
- Reset mid-round: everything returns to reset values the next cycle, including pend and the buffer pointers.
- Buffer pointers wrap modulo DEPTH.

## Test plan
- Load the 3×3 board:
  - Options: R0 {110,011}, R1 {100,010,001}, R2 {101}, C0 {101}, C1 {110,011}, C2 {100,010,001}.
  - Required: after load_last, started pulses once; old_options_amnt = 2,3,1,1,2,3.
  - Required: 18 consecutive beats 000,110,011,001,100,010,001,010,101,011,101,100,110,011,101,100,010,001.
- Round-1 verdicts: drop R2 101, C0 101, C1 110, C2 010, C2 001; keep all others.
  - Required: round-2 counts 2,3,0,0,1,1.
  - Required: round-2 stream 000,110,011,001,100,010,001,010,011,100,011,101,100.
- Solver keeps every option in a round → stuck=1, done=0, busy=0; counts unchanged.
- solved=1 in CHECK → done=1, no further option_valid.
- Load DEPTH+1 beats → overflow=1; the first DEPTH entries are retained.
- Assert rst=0 mid-OPTS → next cycle all outputs are at reset values; a reload replays round 1 identically.

Source files
------------

// File: rtl/option_feeder_if.sv
// Bundle of the load bus, solver verdict inputs and option stream outputs of option_feeder.
// master is the loader/solver side, slave is the feeder itself.
interface option_feeder_if #(
    parameter int MAX_ROWS = 3,
    parameter int MAX_COLS = 3,
    parameter int CW       = 7
);
    localparam int W   = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
    localparam int L   = MAX_ROWS + MAX_COLS;
    localparam int LW  = $clog2(L);
    localparam int RW  = $clog2(MAX_ROWS + 1);
    localparam int CLW = $clog2(MAX_COLS + 1);

    logic [RW-1:0]   num_rows;
    logic [CLW-1:0]  num_cols;
    logic            load_valid;
    logic [LW-1:0]   load_line;
    logic [W-1:0]    load_option;
    logic            load_last;
    logic            load_ready;
    logic            put_back_to_FIFO;
    logic            solved;
    logic            started;
    logic [W-1:0]    option;
    logic            option_valid;
    logic [L*CW-1:0] old_options_amnt;
    logic            busy;
    logic            done;
    logic            stuck;
    logic            overflow;

    modport master (
        output num_rows, num_cols, load_valid, load_line, load_option, load_last,
               put_back_to_FIFO, solved,
        input  load_ready, started, option, option_valid, old_options_amnt,
               busy, done, stuck, overflow
    );

    modport slave (
        input  num_rows, num_cols, load_valid, load_line, load_option, load_last,
               put_back_to_FIFO, solved,
        output load_ready, started, option, option_valid, old_options_amnt,
               busy, done, stuck, overflow
    );
endinterface

// File: rtl/option_feeder.sv
// Streams every candidate option line by line to the solver each round and recycles
// the options the solver keeps through a circular buffer until solved or no progress.
module option_feeder #(
    parameter int MAX_ROWS = 3,
    parameter int MAX_COLS = 3,
    parameter int DEPTH    = 64,
    parameter int CW       = 7
) (
    input  logic           clk,
    input  logic           rst,
    option_feeder_if.slave bus
);
    localparam int W  = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
    localparam int L  = MAX_ROWS + MAX_COLS;
    localparam int LW = $clog2(L);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = LW + W;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_INDEX, S_OPTS, S_FLUSH, S_CHECK, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_head_data;
    logic [EW-1:0] r_pend;
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_occ;
    logic [CW-1:0] r_count [L];
    logic [CW-1:0] r_new [L];
    logic [CW-1:0] r_rem;
    logic [LW-1:0] r_line;
    logic [LW:0]   r_num_lines;
    logic          r_pend_valid, r_removed_any, r_done, r_stuck, r_overflow;

    logic          w_load, w_full, w_load_wr, w_push, w_pop, w_we, w_last_line;
    logic [AW-1:0] w_ra;
    logic [EW-1:0] w_wd;
    logic [LW-1:0] w_pend_line;

    assign w_pop       = (r_state == S_OPTS);
    assign w_load      = (r_state == S_IDLE) && bus.load_valid;
    assign w_full      = (r_occ == (AW+1)'(DEPTH));
    assign w_load_wr   = w_load && !w_full;
    assign w_push      = r_pend_valid && bus.put_back_to_FIFO;
    assign w_we        = w_load_wr || w_push;
    assign w_wd        = w_push ? r_pend : {bus.load_line, bus.load_option};
    assign w_ra        = w_pop ? r_head + AW'(1) : r_head;
    assign w_last_line = ({1'b0, r_line} == r_num_lines - (LW+1)'(1));
    assign w_pend_line = r_pend[EW-1:W];

    // Registered read prefetches the next head; a same-cycle write to that slot is forwarded.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_tail] <= w_wd;
        end
        r_head_data <= (w_we && (r_tail == w_ra)) ? w_wd : r_mem[w_ra];
    end

    always_comb begin
        w_state_next     = r_state;
        bus.started      = 1'b0;
        bus.option_valid = 1'b0;
        bus.option       = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.load_valid && bus.load_last) w_state_next = S_START;
            end
            S_START: begin
                bus.started  = 1'b1;
                w_state_next = S_INDEX;
            end
            S_INDEX: begin
                bus.option_valid = 1'b1;
                bus.option       = W'(r_line);
                if (r_count[r_line] != '0) w_state_next = S_OPTS;
                else if (w_last_line)      w_state_next = S_FLUSH;
            end
            S_OPTS: begin
                bus.option_valid = 1'b1;
                bus.option       = r_head_data[W-1:0];
                if (r_rem == CW'(1)) w_state_next = w_last_line ? S_FLUSH : S_INDEX;
            end
            S_FLUSH: w_state_next = S_CHECK;
            S_CHECK: w_state_next = (bus.solved || !r_removed_any) ? S_DONE : S_INDEX;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_head        <= '0;
            r_tail        <= '0;
            r_occ         <= '0;
            r_pend        <= '0;
            r_pend_valid  <= 1'b0;
            r_rem         <= '0;
            r_line        <= '0;
            r_num_lines   <= '0;
            r_removed_any <= 1'b0;
            r_done        <= 1'b0;
            r_stuck       <= 1'b0;
            r_overflow    <= 1'b0;
            for (int i = 0; i < L; i++) begin
                r_count[i] <= '0;
                r_new[i]   <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_pend_valid <= w_pop;
            if (w_pop) begin
                r_pend <= r_head_data;
                r_head <= r_head + AW'(1);
            end
            if (w_we) r_tail <= r_tail + AW'(1);
            if (w_we && !w_pop)      r_occ <= r_occ + (AW+1)'(1);
            else if (!w_we && w_pop) r_occ <= r_occ - (AW+1)'(1);
            if (w_load && w_full) r_overflow <= 1'b1;
            if (w_load_wr) r_count[bus.load_line] <= r_count[bus.load_line] + CW'(1);
            if (w_load && bus.load_last) begin
                r_num_lines <= (LW+1)'(bus.num_rows) + (LW+1)'(bus.num_cols);
            end
            if (w_push) r_new[w_pend_line] <= r_new[w_pend_line] + CW'(1);
            if (r_pend_valid && !bus.put_back_to_FIFO) r_removed_any <= 1'b1;

            case (r_state)
                S_START: r_line <= '0;
                S_INDEX: begin
                    r_rem <= r_count[r_line];
                    if ((r_count[r_line] == '0) && !w_last_line) r_line <= r_line + LW'(1);
                end
                S_OPTS: begin
                    r_rem <= r_rem - CW'(1);
                    if ((r_rem == CW'(1)) && !w_last_line) r_line <= r_line + LW'(1);
                end
                S_CHECK: begin
                    for (int i = 0; i < L; i++) begin
                        r_count[i] <= r_new[i];
                        r_new[i]   <= '0;
                    end
                    r_removed_any <= 1'b0;
                    r_line        <= '0;
                    if (bus.solved)          r_done  <= 1'b1;
                    else if (!r_removed_any) r_stuck <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_cnt
            assign bus.old_options_amnt[gi*CW +: CW] = r_count[gi];
        end
    endgenerate

    assign bus.load_ready = (r_state == S_IDLE);
    assign bus.busy       = !((r_state == S_IDLE) || (r_state == S_DONE));
    assign bus.done       = r_done;
    assign bus.stuck      = r_stuck;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_option_feeder.sv
// Bench for option_feeder: a per-line queue model predicts every cycle of a session,
// and the DUT is compared against it cycle by cycle.
module tb_option_feeder;
    localparam int MAX_ROWS = 3;
    localparam int MAX_COLS = 3;
    localparam int DEPTH    = 64;
    localparam int CW       = 7;
    localparam int W        = 3;
    localparam int L        = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    option_feeder_if #(.MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS), .CW(CW)) bus ();

    option_feeder #(.MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic            started;
        logic            busy;
        logic            valid;
        logic [W-1:0]    opt;
        logic [L*CW-1:0] cnt;
        logic            done;
        logic            stuck;
        logic            ovf;
        logic            load_ready;
    } obs_t;

    typedef struct {
        obs_t o;
        logic pb;
        logic sv;
    } rec_t;

    rec_t         recs[$];
    logic [W-1:0] mq [L][$];
    logic [W-1:0] nq [L][$];
    logic         m_ovf, m_done, m_stuck;
    int           mode;
    int           n_cmp = 0;
    int           n_err = 0;

    logic [2:0] lit [31] = '{
        3'b000, 3'b110, 3'b011, 3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b101,
        3'b011, 3'b101, 3'b100, 3'b110, 3'b011, 3'b101, 3'b100, 3'b010, 3'b001,
        3'b000, 3'b110, 3'b011, 3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b011,
        3'b100, 3'b011, 3'b101, 3'b100};
    int         brd_line [12] = '{0, 0, 1, 1, 1, 2, 3, 4, 4, 5, 5, 5};
    logic [2:0] brd_opt  [12] = '{3'b110, 3'b011, 3'b100, 3'b010, 3'b001, 3'b101,
                                  3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001};

    function automatic logic rbit();
        return ($urandom & 1) == 1;
    endfunction

    // Solver policy: mode 0 drops the planned round-1 options, mode 1 keeps all, mode 2 drops all.
    function automatic logic keep_fn(int md, int rnd, int line, logic [W-1:0] o);
        if (md == 2) return 1'b0;
        if (md == 0 && rnd == 1) begin
            if ((line == 2 && o == 3'b101) || (line == 3 && o == 3'b101) ||
                (line == 4 && o == 3'b110) || (line == 5 && o == 3'b010) ||
                (line == 5 && o == 3'b001)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [L*CW-1:0] cnt_vec();
        logic [L*CW-1:0] v = '0;
        for (int l = 0; l < L; l++) v[l*CW +: CW] = CW'(mq[l].size());
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.started    = bus.started;
        a.busy       = bus.busy;
        a.valid      = bus.option_valid;
        a.opt        = bus.option_valid ? bus.option : '0;
        a.cnt        = bus.old_options_amnt;
        a.done       = bus.done;
        a.stuck      = bus.stuck;
        a.ovf        = bus.overflow;
        a.load_ready = bus.load_ready;
        return a;
    endfunction

    task automatic check_obs(string nm, obs_t e);
        obs_t a = sample();
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic check_val(string nm, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic push_rec(logic st, logic bz, logic vl, logic [W-1:0] op, logic pb, logic sv);
        rec_t r;
        r.o.started    = st;
        r.o.busy       = bz;
        r.o.valid      = vl;
        r.o.opt        = vl ? op : '0;
        r.o.cnt        = cnt_vec();
        r.o.done       = m_done;
        r.o.stuck      = m_stuck;
        r.o.ovf        = m_ovf;
        r.o.load_ready = 1'b0;
        r.pb           = pb;
        r.sv           = sv;
        recs.push_back(r);
    endtask

    // Builds the whole cycle-by-cycle expectation from the load contents and solver policy.
    task automatic gen();
        logic prev_opt = 1'b0;
        logic prev_keep = 1'b0;
        logic removed, sv;
        logic fin = 1'b0;
        int   rnd = 1;
        recs.delete();
        push_rec(1'b1, 1'b1, 1'b0, '0, rbit(), rbit());
        while (!fin) begin
            removed = 1'b0;
            for (int l = 0; l < L; l++) nq[l].delete();
            for (int l = 0; l < L; l++) begin
                push_rec(1'b0, 1'b1, 1'b1, W'(l), prev_opt ? prev_keep : rbit(), rbit());
                prev_opt = 1'b0;
                for (int k = 0; k < mq[l].size(); k++) begin
                    push_rec(1'b0, 1'b1, 1'b1, mq[l][k], prev_opt ? prev_keep : rbit(), rbit());
                    prev_opt  = 1'b1;
                    prev_keep = keep_fn(mode, rnd, l, mq[l][k]);
                    if (prev_keep) nq[l].push_back(mq[l][k]);
                    else removed = 1'b1;
                end
            end
            push_rec(1'b0, 1'b1, 1'b0, '0, prev_opt ? prev_keep : rbit(), rbit());
            prev_opt = 1'b0;
            sv = (mode == 1);
            push_rec(1'b0, 1'b1, 1'b0, '0, rbit(), sv);
            for (int l = 0; l < L; l++) mq[l] = nq[l];
            if (sv) begin
                m_done = 1'b1;
                fin    = 1'b1;
            end else if (!removed) begin
                m_stuck = 1'b1;
                fin     = 1'b1;
            end
            rnd++;
        end
        repeat (4) push_rec(1'b0, 1'b0, 1'b0, '0, rbit(), rbit());
    endtask

    task automatic play(int n);
        for (int i = 0; i < n; i++) begin
            bus.put_back_to_FIFO = recs[i].pb;
            bus.solved           = recs[i].sv;
            check_obs($sformatf("cycle%0d", i), recs[i].o);
            if (bus.option_valid) $display("beat %0d option=%b", i, bus.option);
            @(negedge clk);
        end
        bus.put_back_to_FIFO = 1'b0;
        bus.solved           = 1'b0;
    endtask

    task automatic check_reset(string nm);
        obs_t e = '0;
        e.load_ready = 1'b1;
        check_obs(nm, e);
    endtask

    task automatic do_reset();
        rst                  = 1'b0;
        bus.load_valid       = 1'b0;
        bus.load_last        = 1'b0;
        bus.load_line        = '0;
        bus.load_option      = '0;
        bus.put_back_to_FIFO = 1'b0;
        bus.solved           = 1'b0;
        bus.num_rows         = 2'd3;
        bus.num_cols         = 2'd3;
        for (int l = 0; l < L; l++) mq[l].delete();
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        m_stuck = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;
    endtask

    task automatic load_beat(int line, logic [W-1:0] o, logic last);
        int total = 0;
        bus.load_valid  = 1'b1;
        bus.load_line   = 3'(line);
        bus.load_option = o;
        bus.load_last   = last;
        for (int l = 0; l < L; l++) total += mq[l].size();
        if (total >= DEPTH) m_ovf = 1'b1;
        else mq[line].push_back(o);
        check_val("idle_ready_busy", {62'd0, bus.load_ready, bus.busy}, 64'd2);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic load_board();
        for (int i = 0; i < 12; i++) load_beat(brd_line[i], brd_opt[i], i == 11);
        $display("loaded 3x3 board");
    endtask

    initial begin
        int k;
        // Session A: planned verdicts, round 2 keeps everything and sticks
        do_reset();
        mode = 0;
        load_board();
        gen();
        k = 0;
        foreach (recs[i]) begin
            if (recs[i].o.valid) begin
                if (k < 31) check_val($sformatf("model_beat%0d", k), 64'(recs[i].o.opt), 64'(lit[k]));
                k++;
            end
        end
        check_val("model_beats", 64'(k), 64'd31);
        check_val("model_cnt_r1", 64'(recs[0].o.cnt),
                  64'({7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd2}));
        check_val("model_cnt_r2", 64'(recs[recs.size()-1].o.cnt),
                  64'({7'd1, 7'd1, 7'd0, 7'd0, 7'd3, 7'd2}));
        check_val("model_stuck", 64'({recs[recs.size()-1].o.stuck, recs[recs.size()-1].o.done}), 64'd2);
        play(recs.size());
        $display("session planned-verdicts finished");

        // Session D: reset in the middle of an option beat, then replay
        do_reset();
        load_board();
        gen();
        play(3);
        check_obs("pre_reset_opts", recs[3].o);
        rst = 1'b0;
        @(negedge clk);
        check_reset("mid_opts_reset");
        do_reset();
        load_board();
        gen();
        play(recs.size());
        $display("session reset-replay finished");

        // Session B: solver keeps all and reports solved
        do_reset();
        mode = 1;
        load_board();
        gen();
        check_val("model_done", 64'({recs[recs.size()-1].o.stuck, recs[recs.size()-1].o.done}), 64'd1);
        play(recs.size());
        $display("session solved finished");

        // Session C: DEPTH+1 load beats, last one dropped
        do_reset();
        mode = 2;
        for (int i = 0; i < DEPTH; i++) load_beat(0, 3'(i % 8), 1'b0);
        load_beat(5, 3'b111, 1'b1);
        gen();
        check_val("model_ovf_cnt", 64'(recs[0].o.cnt), 64'({7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd64}));
        check_val("model_ovf_flag", 64'(recs[0].o.ovf), 64'd1);
        play(recs.size());
        $display("session overflow finished");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
